cpu_runctl: RTL

- Sits directly downstream of the HPS start/stop control unit. Consumes its alive and halt_clr outputs and returns cpu_halt to it.
- Drives the soft CPU core's reset and clock-enable.
- Latches the cause of every stop and counts executed run cycles, with an optional watchdog, for HPS status readback.

---
 rtl/cpu_runctl_if.sv | 26 ++
 rtl/cpu_runctl.sv | 100 ++++++++++
 2 files changed

// File: rtl/cpu_runctl_if.sv
// Control-unit / CPU-core side signals of the run controller.
// The master drives the inputs, the slave is the run controller itself.
interface cpu_runctl_if #(
  parameter int CNT_W = 32
);
  logic             alive;
  logic             halt_clr;
  logic             halt_req;
  logic [CNT_W-1:0] wdog_limit;
  logic             cpu_halt;
  logic             cpu_rst;
  logic             cpu_en;
  logic [CNT_W-1:0] run_cycles;
  logic [1:0]       halt_cause;
  logic [1:0]       run_state;

  modport master (
    output alive, halt_clr, halt_req, wdog_limit,
    input  cpu_halt, cpu_rst, cpu_en, run_cycles, halt_cause, run_state
  );

  modport slave (
    input  alive, halt_clr, halt_req, wdog_limit,
    output cpu_halt, cpu_rst, cpu_en, run_cycles, halt_cause, run_state
  );
endinterface

// File: rtl/cpu_runctl.sv
// Soft-CPU run controller: sequences core reset/enable, records why the core
// stopped and counts run cycles with an optional watchdog.
module cpu_runctl #(
  parameter int RST_CYCLES = 4,
  parameter int CNT_W      = 32
) (
  input  logic          clk,
  input  logic          rst,
  cpu_runctl_if.slave   bus
);
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RESET = 2'b01;
  localparam logic [1:0] S_RUN   = 2'b10;
  localparam logic [1:0] S_HALT  = 2'b11;

  localparam int             RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_INIT = RC_W'(RST_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [RC_W-1:0]  rcnt_q, rcnt_d;
  logic [CNT_W-1:0] cyc_q, cyc_d, cyc_sat;
  logic [CNT_W:0]   cyc_p1;
  logic [1:0]       cause_q, cause_d;
  logic             flag_q, flag_d;
  logic             wdog_hit;

  assign cyc_sat  = (&cyc_q) ? cyc_q : cyc_q + CNT_W'(1);
  // Compare one bit wider so the saturated count still trips any nonzero limit.
  assign cyc_p1   = {1'b0, cyc_q} + {{CNT_W{1'b0}}, 1'b1};
  assign wdog_hit = (bus.wdog_limit != '0) && (cyc_p1 >= {1'b0, bus.wdog_limit});

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    cyc_d   = cyc_q;
    cause_d = cause_q;
    flag_d  = flag_q;
    if (bus.halt_clr) begin
      // A start from any state, including RESET/RUN, restarts the sequence.
      state_d = S_RESET;
      rcnt_d  = RC_INIT;
      cyc_d   = '0;
      cause_d = 2'b00;
      flag_d  = 1'b0;
    end else begin
      case (state_q)
        S_RESET: begin
          if (!bus.alive) begin
            cause_d = 2'b11;
            state_d = S_IDLE;
          end else if (rcnt_q == '0) begin
            state_d = S_RUN;
          end else begin
            rcnt_d = rcnt_q - RC_W'(1);
          end
        end
        S_RUN: begin
          cyc_d = cyc_sat;
          if (!bus.alive) begin
            cause_d = 2'b11;
            state_d = S_HALT;
          end else if (bus.halt_req) begin
            cause_d = 2'b01;
            flag_d  = 1'b1;
            state_d = S_HALT;
          end else if (wdog_hit) begin
            cause_d = 2'b10;
            flag_d  = 1'b1;
            state_d = S_HALT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rcnt_q  <= '0;
      cyc_q   <= '0;
      cause_q <= 2'b00;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      cyc_q   <= cyc_d;
      cause_q <= cause_d;
      flag_q  <= flag_d;
    end
  end

  // Mask with halt_clr so the control unit never sees a stale halt right after a start.
  assign bus.cpu_halt   = flag_q & ~bus.halt_clr;
  assign bus.cpu_rst    = ~state_q[1];
  assign bus.cpu_en     = (state_q == S_RUN);
  assign bus.run_cycles = cyc_q;
  assign bus.halt_cause = cause_q;
  assign bus.run_state  = state_q;
endmodule
